// File: rtl/dff_bank_rr_arbiter_if.sv
// Requester/storage bus for dff_bank_rr_arbiter: per-requester req and data in,
// grant, owner index, shared register contents and write acknowledges out.
interface dff_bank_rr_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
);
  localparam int OW = $clog2(N_REQ);

  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] wr_data;
  logic [N_REQ-1:0]       gnt;
  logic [OW-1:0]          owner;
  logic [WIDTH-1:0]       q;
  logic                   q_valid;
  logic [N_REQ-1:0]       wr_ack;

  modport master (output req, wr_data, input gnt, owner, q, q_valid, wr_ack);
  modport slave  (input req, wr_data, output gnt, owner, q, q_valid, wr_ack);
endinterface

// File: rtl/dff_bank_rr_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit register among N_REQ requesters; grant one edge after req, write the next.
// Owner keeps the grant while req is held; DFF_ARB_HOLD_LIMIT_EN forces a yield after MAX_HOLD writes.
module dff_bank_rr_arbiter #(
  parameter int N_REQ    = 4,
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input logic                clk,
  input logic                rst,
  dff_bank_rr_arbiter_if.slave bus
);
  localparam int OW = $clog2(N_REQ);
  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state;
  logic [OW-1:0]     ptr;
  logic [OW-1:0]     owner_r;
  logic [N_REQ-1:0]  gnt_r;
  logic [N_REQ-1:0]  ack_r;
  logic [WIDTH-1:0]  q_r;
  logic              q_valid_r;

  logic [OW-1:0]     nxt;
  logic [OW-1:0]     sel_idle;
  logic [OW-1:0]     sel_rel;
  logic              wr_en;
  logic              rel;

  // First set request bit scanning start, start+1, ... modulo N_REQ.
  function automatic logic [OW-1:0] rr_pick(input logic [N_REQ-1:0] r, input logic [OW-1:0] start);
    logic [OW-1:0] pick;
    logic [OW-1:0] j;
    pick = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = OW'((int'(start) + k) % N_REQ);
      if (r[j]) pick = j;
    end
    return pick;
  endfunction

`ifdef DFF_ARB_HOLD_LIMIT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);
  logic [HW-1:0] hold_cnt;
  logic          hold_hit;
  assign hold_hit = (hold_cnt == HW'(MAX_HOLD - 1));
`else
  logic unused_hold_cfg;
  assign unused_hold_cfg = (MAX_HOLD >= 1);
`endif

  always_comb begin
    nxt      = OW'((int'(owner_r) + 1) % N_REQ);
    sel_idle = rr_pick(bus.req, ptr);
    // Scanning from owner+1 puts the current owner last, so it is re-granted only when alone.
    sel_rel  = rr_pick(bus.req, nxt);
    wr_en    = (state == GRANT) && bus.req[owner_r];
`ifdef DFF_ARB_HOLD_LIMIT_EN
    rel      = (state == GRANT) && (!bus.req[owner_r] || hold_hit);
`else
    rel      = (state == GRANT) && !bus.req[owner_r];
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      ptr       <= '0;
      owner_r   <= '0;
      gnt_r     <= '0;
      ack_r     <= '0;
      q_r       <= '0;
      q_valid_r <= 1'b0;
`ifdef DFF_ARB_HOLD_LIMIT_EN
      hold_cnt  <= '0;
`endif
    end else begin
      ack_r <= wr_en ? (ONE << owner_r) : '0;
      if (wr_en) begin
        q_r       <= bus.wr_data[owner_r*WIDTH +: WIDTH];
        q_valid_r <= 1'b1;
      end

      if (state == IDLE) begin
        if (|bus.req) begin
          state   <= GRANT;
          owner_r <= sel_idle;
          gnt_r   <= ONE << sel_idle;
`ifdef DFF_ARB_HOLD_LIMIT_EN
          hold_cnt <= '0;
`endif
        end
      end else if (rel) begin
        ptr <= nxt;
        if (|bus.req) begin
          owner_r <= sel_rel;
          gnt_r   <= ONE << sel_rel;
`ifdef DFF_ARB_HOLD_LIMIT_EN
          hold_cnt <= '0;
`endif
        end else begin
          state   <= IDLE;
          owner_r <= '0;
          gnt_r   <= '0;
        end
      end
`ifdef DFF_ARB_HOLD_LIMIT_EN
      else if (wr_en) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
`endif
    end
  end

  assign bus.gnt     = gnt_r;
  assign bus.owner   = owner_r;
  assign bus.q       = q_r;
  assign bus.q_valid = q_valid_r;
  assign bus.wr_ack  = ack_r;
endmodule

// File: tb/tb_dff_bank_rr_arbiter.sv
// Directed bench for dff_bank_rr_arbiter (N_REQ=4, WIDTH=8, MAX_HOLD=4); outputs sampled 1 time unit after each rising edge.
module tb_dff_bank_rr_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  dff_bank_rr_arbiter_if #(.N_REQ(4), .WIDTH(8)) bus ();

  dff_bank_rr_arbiter #(.N_REQ(4), .WIDTH(8), .MAX_HOLD(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req = '0;
    bus.wr_data = '0;
    #2 rst = 1'b0;
    bus.req = 4'b1111;
    bus.wr_data = 32'h44332211;
    tick();
    tick();
    tests++; if (bus.gnt !== 4'b0000) begin fails++; $display("FAIL reset_gnt: got %b want 0000", bus.gnt); end
    tests++; if (bus.owner !== 2'd0) begin fails++; $display("FAIL reset_owner: got %0d want 0", bus.owner); end
    tests++; if (bus.q !== 8'h00) begin fails++; $display("FAIL reset_q: got %h want 00", bus.q); end
    tests++; if (bus.q_valid !== 1'b0) begin fails++; $display("FAIL reset_q_valid: got %b want 0", bus.q_valid); end
    tests++; if (bus.wr_ack !== 4'b0000) begin fails++; $display("FAIL reset_ack: got %b want 0000", bus.wr_ack); end
    @(negedge clk);
    rst = 1'b1;
    bus.req = '0;
    tick();
    tick();
    tests++; if (bus.gnt !== 4'b0000) begin fails++; $display("FAIL idle_gnt: got %b want 0000", bus.gnt); end
    tests++; if (bus.wr_ack !== 4'b0000) begin fails++; $display("FAIL idle_ack: got %b want 0000", bus.wr_ack); end
  endtask

  task automatic test_single();
    bus.wr_data = {8'h33, 8'h22, 8'hA5, 8'h11};
    bus.req = 4'b0010;
    tick();
    tests++; if (bus.gnt !== 4'b0010) begin fails++; $display("FAIL single_gnt_e1: got %b want 0010", bus.gnt); end
    tests++; if (bus.owner !== 2'd1) begin fails++; $display("FAIL single_owner: got %0d want 1", bus.owner); end
    tests++; if (bus.wr_ack !== 4'b0000) begin fails++; $display("FAIL single_ack_e1: got %b want 0000", bus.wr_ack); end
    tests++; if (bus.q !== 8'h00) begin fails++; $display("FAIL single_q_e1: got %h want 00", bus.q); end
    tick();
    tests++; if (bus.q !== 8'hA5) begin fails++; $display("FAIL single_q_e2: got %h want a5", bus.q); end
    tests++; if (bus.wr_ack !== 4'b0010) begin fails++; $display("FAIL single_ack_e2: got %b want 0010", bus.wr_ack); end
    tests++; if (bus.q_valid !== 1'b1) begin fails++; $display("FAIL single_q_valid: got %b want 1", bus.q_valid); end
    bus.req = '0;
    tick();
    tests++; if (bus.gnt !== 4'b0000) begin fails++; $display("FAIL single_release: got %b want 0000", bus.gnt); end
    tests++; if (bus.wr_ack !== 4'b0000) begin fails++; $display("FAIL single_ack_pulse: got %b want 0000", bus.wr_ack); end
    tests++; if (bus.q !== 8'hA5) begin fails++; $display("FAIL single_q_hold: got %h want a5", bus.q); end
  endtask

  task automatic test_simultaneous();
    logic [7:0] dv [4];
    logic [3:0] one_i;
    dv[0] = 8'h11; dv[1] = 8'h22; dv[2] = 8'h33; dv[3] = 8'h44;
    rst = 1'b0;
    #2 rst = 1'b1;
    bus.wr_data = {dv[3], dv[2], dv[1], dv[0]};
    bus.req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      one_i = 4'b0001 << i;
      tick();
      tests++; if (bus.gnt !== one_i) begin fails++; $display("FAIL simul_gnt[%0d]: got %b want %b", i, bus.gnt, one_i); end
      tests++; if (bus.wr_ack !== 4'b0000) begin fails++; $display("FAIL simul_gap_ack[%0d]: got %b want 0000", i, bus.wr_ack); end
      tick();
      tests++; if (bus.q !== dv[i]) begin fails++; $display("FAIL simul_q[%0d]: got %h want %h", i, bus.q, dv[i]); end
      tests++; if (bus.wr_ack !== one_i) begin fails++; $display("FAIL simul_ack[%0d]: got %b want %b", i, bus.wr_ack, one_i); end
      tests++; if (!$onehot0(bus.gnt)) begin fails++; $display("FAIL simul_onehot[%0d]: got %b want one-hot or zero", i, bus.gnt); end
      bus.req[i] = 1'b0;
    end
    tick();
    tests++; if (bus.gnt !== 4'b0000) begin fails++; $display("FAIL simul_idle: got %b want 0000", bus.gnt); end
  endtask

  task automatic test_hold();
    bus.wr_data = {8'h00, 8'h30, 8'h00, 8'h10};
    bus.req = 4'b0101;
    tick();
    tests++; if (bus.gnt !== 4'b0001) begin fails++; $display("FAIL hold_first_gnt: got %b want 0001", bus.gnt); end
`ifdef DFF_ARB_HOLD_LIMIT_EN
    for (int w = 1; w <= 4; w++) begin
      tick();
      tests++; if (bus.wr_ack !== 4'b0001) begin fails++; $display("FAIL hold0_ack[%0d]: got %b want 0001", w, bus.wr_ack); end
      tests++; if (bus.gnt !== ((w == 4) ? 4'b0100 : 4'b0001)) begin fails++; $display("FAIL hold0_gnt[%0d]: got %b", w, bus.gnt); end
    end
    for (int w = 1; w <= 4; w++) begin
      tick();
      tests++; if (bus.wr_ack !== 4'b0100) begin fails++; $display("FAIL hold2_ack[%0d]: got %b want 0100", w, bus.wr_ack); end
      tests++; if (bus.q !== 8'h30) begin fails++; $display("FAIL hold2_q[%0d]: got %h want 30", w, bus.q); end
      tests++; if (bus.gnt !== ((w == 4) ? 4'b0001 : 4'b0100)) begin fails++; $display("FAIL hold2_gnt[%0d]: got %b", w, bus.gnt); end
    end
    tick();
    tests++; if (bus.wr_ack !== 4'b0001) begin fails++; $display("FAIL hold_back_ack: got %b want 0001", bus.wr_ack); end
`else
    for (int w = 1; w <= 8; w++) begin
      tick();
      tests++; if (bus.gnt !== 4'b0001) begin fails++; $display("FAIL hold_keep_gnt[%0d]: got %b want 0001", w, bus.gnt); end
      tests++; if (bus.wr_ack !== 4'b0001) begin fails++; $display("FAIL hold_keep_ack[%0d]: got %b want 0001", w, bus.wr_ack); end
    end
`endif
    tests++; if (bus.q !== 8'h10) begin fails++; $display("FAIL hold_q: got %h want 10", bus.q); end
    bus.req = '0;
    tick();
    tests++; if (bus.gnt !== 4'b0000) begin fails++; $display("FAIL hold_release: got %b want 0000", bus.gnt); end
  endtask

  task automatic test_drop_mid_grant();
    // Pointer is 1 after the previous release of requester 0.
    bus.wr_data = {8'h88, 8'h77, 8'h00, 8'h00};
    bus.req = 4'b0100;
    tick();
    tests++; if (bus.gnt !== 4'b0100) begin fails++; $display("FAIL drop_gnt2: got %b want 0100", bus.gnt); end
    tick();
    bus.req = 4'b1100;
    tick();
    tests++; if (bus.gnt !== 4'b0100) begin fails++; $display("FAIL drop_nonowner_ignored: got %b want 0100", bus.gnt); end
    tests++; if (bus.q !== 8'h77) begin fails++; $display("FAIL drop_q77: got %h want 77", bus.q); end
    bus.req = 4'b1000;
    bus.wr_data = {8'h88, 8'h99, 8'h00, 8'h00};
    tick();
    tests++; if (bus.gnt !== 4'b1000) begin fails++; $display("FAIL drop_gnt3: got %b want 1000", bus.gnt); end
    tests++; if (bus.wr_ack !== 4'b0000) begin fails++; $display("FAIL drop_no_ack: got %b want 0000", bus.wr_ack); end
    tests++; if (bus.q !== 8'h77) begin fails++; $display("FAIL drop_q_unchanged: got %h want 77", bus.q); end
    tick();
    tests++; if (bus.q !== 8'h88) begin fails++; $display("FAIL drop_q88: got %h want 88", bus.q); end
    tests++; if (bus.wr_ack !== 4'b1000) begin fails++; $display("FAIL drop_ack3: got %b want 1000", bus.wr_ack); end
    bus.req = '0;
    tick();
  endtask

  task automatic test_reset_mid();
    bus.wr_data = {8'h00, 8'h00, 8'h5A, 8'hC3};
    bus.req = 4'b0011;
    tick();
    tests++; if (bus.gnt !== 4'b0001) begin fails++; $display("FAIL rmid_gnt0: got %b want 0001", bus.gnt); end
    tick();
    bus.req = 4'b0010;
    tick();
    tests++; if (bus.gnt !== 4'b0010) begin fails++; $display("FAIL rmid_gnt1: got %b want 0010", bus.gnt); end
    tick();
    tests++; if (bus.wr_ack !== 4'b0010) begin fails++; $display("FAIL rmid_ack1: got %b want 0010", bus.wr_ack); end
    #2 rst = 1'b0;
    #1;
    tests++; if (bus.gnt !== 4'b0000) begin fails++; $display("FAIL rmid_async_gnt: got %b want 0000", bus.gnt); end
    tests++; if (bus.q !== 8'h00) begin fails++; $display("FAIL rmid_async_q: got %h want 00", bus.q); end
    tests++; if (bus.wr_ack !== 4'b0000) begin fails++; $display("FAIL rmid_async_ack: got %b want 0000", bus.wr_ack); end
    tests++; if (bus.q_valid !== 1'b0) begin fails++; $display("FAIL rmid_async_qv: got %b want 0", bus.q_valid); end
    bus.req = 4'b0011;
    #1 rst = 1'b1;
    tick();
    tests++; if (bus.gnt !== 4'b0001) begin fails++; $display("FAIL rmid_restart_ptr0: got %b want 0001", bus.gnt); end
    tests++; if (bus.q_valid !== 1'b0) begin fails++; $display("FAIL rmid_restart_qv: got %b want 0", bus.q_valid); end
    tick();
    tests++; if (bus.q !== 8'hC3) begin fails++; $display("FAIL rmid_restart_q: got %h want c3", bus.q); end
    tests++; if (bus.q_valid !== 1'b1) begin fails++; $display("FAIL rmid_restart_qv1: got %b want 1", bus.q_valid); end
    bus.req = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_hold();
    test_drop_mid_grant();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
